// File: rtl/qeciphy_traffic_checker_pkg.sv
// Shared types and constants for the QECIPHY link-test traffic path.
// Used by the RX traffic checker, its pattern generator and the AXI4-Stream interface.
package qeciphy_traffic_checker_pkg;

  localparam int unsigned DataWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } checker_state_t;

  typedef enum logic [0:0] {
    PatCounter,
    PatPrbs
  } pattern_mode_t;

  // Feedback taps of x^64+x^63+x^61+x^60+1 (state bits 63, 62, 60, 59).
  localparam logic [63:0] PrbsTaps        = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DefaultPrbsSeed = 64'h0123_4567_89AB_CDEF;

  // FLAGS bit positions: {OVERFLOW, TIMEOUT, LINK_LOST}.
  localparam int unsigned FlagLinkLost = 0;
  localparam int unsigned FlagTimeout  = 1;
  localparam int unsigned FlagOverflow = 2;

  // One step of the Fibonacci LFSR; shared by both ends of the link test.
  function automatic logic [63:0] prbs_next(input logic [63:0] s);
    return {s[62:0], ^(s & PrbsTaps)};
  endfunction

endpackage

// File: rtl/qeciphy_traffic_checker_if.sv
// AXI4-Stream data channel (TDATA/TVALID/TREADY) as seen at the QECIPHY RX user interface.
// master: traffic source drives tdata/tvalid; slave: sink drives tready.
interface qeciphy_traffic_checker_if
  import qeciphy_traffic_checker_pkg::*;
();
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/qeciphy_traffic_checker_pattern_gen.sv
// Link-test pattern generator: counter (wrapping 64-bit increment) or 64-bit Fibonacci PRBS.
// Ports: clk_i/rst_i (sync active-high), load_i (restart sequence, latch mode_i),
//        advance_i (step to next word), mode_i, data_o (current expected word).
module qeciphy_pattern_gen
  import qeciphy_traffic_checker_pkg::*;
#(
  parameter logic [63:0] Seed = DefaultPrbsSeed
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          advance_i,
  input  pattern_mode_t mode_i,
  output logic [63:0]   data_o
);

  pattern_mode_t mode_q, mode_d;
  logic [63:0]   data_q, data_d;

  always_comb begin
    mode_d = mode_q;
    data_d = data_q;
    if (load_i) begin
      mode_d = mode_i;
      data_d = (mode_i == PatPrbs) ? Seed : 64'd0;
    end else if (advance_i) begin
      data_d = (mode_q == PatPrbs) ? prbs_next(data_q) : data_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= PatCounter;
      data_q <= 64'd0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/qeciphy_traffic_checker.sv
// AXI4-Stream sink for the QECIPHY RX link test: regenerates the counter/PRBS sequence,
// compares every accepted beat and reports counts, first-error detail and a verdict.
// Ports: ACLK/ARST (sync active-high), START/MODE run control, LINK_READY link status,
//        rx (stream slave), BUSY/DONE/PASS status, RX_CNT, ERR_CNT, FIRST_ERR_IDX,
//        FIRST_ERR_DATA, FLAGS {OVERFLOW, TIMEOUT, LINK_LOST}.
module qeciphy_traffic_checker
  import qeciphy_traffic_checker_pkg::*;
#(
  parameter int unsigned SEQ_LEN        = 2048,
  parameter logic [63:0] PRBS_SEED      = DefaultPrbsSeed,
  parameter int unsigned TIMEOUT_CYCLES = 32'h0002_0000
) (
  input  logic                      ACLK,
  input  logic                      ARST,
  input  logic                      START,
  input  logic                      MODE,
  input  logic                      LINK_READY,
  qeciphy_traffic_checker_if.slave  rx,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      PASS,
  output logic [31:0]               RX_CNT,
  output logic [15:0]               ERR_CNT,
  output logic [31:0]               FIRST_ERR_IDX,
  output logic [63:0]               FIRST_ERR_DATA,
  output logic [2:0]                FLAGS
);

  checker_state_t state_q, state_d;
  logic [31:0]    rx_cnt_q, rx_cnt_d;
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [31:0]    first_err_idx_q, first_err_idx_d;
  logic [63:0]    first_err_data_q, first_err_data_d;
  logic [2:0]     flags_q, flags_d;
  logic [31:0]    run_cyc_q, run_cyc_d;

  logic        tready;
  logic        accept;
  logic        start_ok;
  logic        last_beat;
  logic        timed_out;
  logic [63:0] expected;

  assign tready   = (state_q == StRun) || (state_q == StDone);
  assign accept   = rx.tvalid && tready;
  assign start_ok = START && ((state_q == StIdle) || (state_q == StDone));

  qeciphy_pattern_gen #(
    .Seed (PRBS_SEED)
  ) u_pattern_gen (
    .clk_i     (ACLK),
    .rst_i     (ARST),
    .load_i    (start_ok),
    .advance_i (accept && (state_q == StRun)),
    .mode_i    (pattern_mode_t'(MODE)),
    .data_o    (expected)
  );

  always_comb begin
    state_d          = state_q;
    rx_cnt_d         = rx_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    flags_d          = flags_q;
    run_cyc_d        = run_cyc_q;
    last_beat        = 1'b0;
    timed_out        = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // Drained beats after the run are only flagged, never compared or counted.
        if ((state_q == StDone) && accept) flags_d[FlagOverflow] = 1'b1;
        if (START) begin
          state_d          = StArmed;
          rx_cnt_d         = '0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          flags_d          = '0;
        end
      end
      StArmed: begin
        if (LINK_READY) begin
          state_d   = StRun;
          run_cyc_d = '0;
        end
      end
      StRun: begin
        run_cyc_d = run_cyc_q + 32'd1;
        if (accept) begin
          rx_cnt_d = rx_cnt_q + 32'd1;
          if (rx.tdata != expected) begin
            // A zero count means no mismatch yet; saturation never wraps it back to zero.
            if (err_cnt_q == '0) begin
              first_err_idx_d  = rx_cnt_q;
              first_err_data_d = rx.tdata;
            end
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
        end
        last_beat = accept && (rx_cnt_q == 32'(SEQ_LEN - 1));
        // A run that completes on its last allowed cycle is not a timeout.
        timed_out = (run_cyc_q == 32'(TIMEOUT_CYCLES - 1)) && !last_beat;
        if (!LINK_READY) flags_d[FlagLinkLost] = 1'b1;
        if (timed_out)   flags_d[FlagTimeout]  = 1'b1;
        if (last_beat || !LINK_READY || timed_out) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q          <= StIdle;
      rx_cnt_q         <= '0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      flags_q          <= '0;
      run_cyc_q        <= '0;
    end else begin
      state_q          <= state_d;
      rx_cnt_q         <= rx_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      flags_q          <= flags_d;
      run_cyc_q        <= run_cyc_d;
    end
  end

  assign rx.tready      = tready;
  assign BUSY           = (state_q == StArmed) || (state_q == StRun);
  assign DONE           = (state_q == StDone);
  assign PASS           = (state_q == StDone) && (flags_q == '0) && (err_cnt_q == '0);
  assign RX_CNT         = rx_cnt_q;
  assign ERR_CNT        = err_cnt_q;
  assign FIRST_ERR_IDX  = first_err_idx_q;
  assign FIRST_ERR_DATA = first_err_data_q;
  assign FLAGS          = flags_q;

endmodule

// File: tb/tb_qeciphy_traffic_checker.sv
// Bench for qeciphy_traffic_checker: directed and randomized runs checked every cycle against
// a phase-level behavioural model, plus literal expectations for the key scenarios.
module tb_qeciphy_traffic_checker;
  import qeciphy_traffic_checker_pkg::*;

  localparam int unsigned SeqLen = 16;
  localparam int unsigned Tmo    = 100;
  localparam logic [63:0] Seed   = 64'h0123_4567_89AB_CDEF;

  localparam int PhIdle  = 0;
  localparam int PhArmed = 1;
  localparam int PhRun   = 2;
  localparam int PhDone  = 3;

  logic        clk = 1'b0;
  logic        arst, start, mode, link;
  logic        busy, done, pass;
  logic [31:0] rx_cnt, first_err_idx;
  logic [15:0] err_cnt;
  logic [63:0] first_err_data;
  logic [2:0]  flags;

  qeciphy_traffic_checker_if rx_if ();

  qeciphy_traffic_checker #(
    .SEQ_LEN        (SeqLen),
    .PRBS_SEED      (Seed),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .ACLK           (clk),
    .ARST           (arst),
    .START          (start),
    .MODE           (mode),
    .LINK_READY     (link),
    .rx             (rx_if.slave),
    .BUSY           (busy),
    .DONE           (done),
    .PASS           (pass),
    .RX_CNT         (rx_cnt),
    .ERR_CNT        (err_cnt),
    .FIRST_ERR_IDX  (first_err_idx),
    .FIRST_ERR_DATA (first_err_data),
    .FLAGS          (flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] prbs_tab [64];

  // Model state: what the outputs must show after the most recent clock edge.
  int          m_phase;
  logic [31:0] m_rx, m_fidx;
  logic [15:0] m_err;
  logic [63:0] m_fdata;
  logic [2:0]  m_flags;
  int          m_runcyc;
  bit          m_mode;
  bit          m_acc;

  function automatic logic [63:0] pattern(input bit md, input int i);
    return md ? prbs_tab[i] : 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_rx = '0; m_err = '0; m_fidx = '0; m_fdata = '0; m_flags = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit ready, fin, to;
    ready = (m_phase == PhRun) || (m_phase == PhDone);
    m_acc = 1'b0;
    if (arst) begin
      m_phase = PhIdle; model_clear(); m_runcyc = 0;
      return;
    end
    m_acc = rx_if.tvalid && ready;
    case (m_phase)
      PhIdle: if (start) begin model_clear(); m_mode = mode; m_phase = PhArmed; end
      PhArmed: if (link) begin m_phase = PhRun; m_runcyc = 0; end
      PhRun: begin
        if (m_acc) begin
          if (rx_if.tdata != pattern(m_mode, int'(m_rx))) begin
            if (m_err == 0) begin m_fidx = m_rx; m_fdata = rx_if.tdata; end
            if (m_err != 16'hFFFF) m_err = m_err + 1;
          end
          m_rx = m_rx + 1;
        end
        fin = m_acc && (m_rx == SeqLen);
        m_runcyc++;
        to = (m_runcyc == Tmo) && !fin;
        if (!link) m_flags[0] = 1'b1;
        if (to) m_flags[1] = 1'b1;
        if (fin || !link || to) m_phase = PhDone;
      end
      default: begin
        if (start) begin model_clear(); m_mode = mode; m_phase = PhArmed; end
        else if (m_acc) m_flags[2] = 1'b1;
      end
    endcase
  endtask

  task automatic check_all();
    chk("tready", 64'(rx_if.tready), 64'((m_phase == PhRun) || (m_phase == PhDone)));
    chk("busy", 64'(busy), 64'((m_phase == PhArmed) || (m_phase == PhRun)));
    chk("done", 64'(done), 64'(m_phase == PhDone));
    chk("pass", 64'(pass), 64'((m_phase == PhDone) && (m_flags == 0) && (m_err == 0)));
    chk("rx_cnt", 64'(rx_cnt), 64'(m_rx));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("first_err_idx", 64'(first_err_idx), 64'(m_fidx));
    chk("first_err_data", first_err_data, m_fdata);
    chk("flags", 64'(flags), 64'(m_flags));
  endtask

  // Inputs are already set; step the model, then compare just before the next edge's inputs.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_start(input bit md);
    start = 1'b1; mode = md; link = 1'b1; rx_if.tvalid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  // Source sends the expected sequence (with optional corruption) until the model reports DONE.
  task automatic run_traffic(input int gap_pct, input int bad_a, input int bad_b,
                             input int drop_at, input bit drop_on_last, input bit rnd_start);
    int src = 0;
    int cyc = 0;
    while (m_phase != PhDone && cyc < 300) begin
      link  = 1'b1;
      start = rnd_start && ($urandom_range(0, 19) == 0);
      mode  = 1'($urandom);
      rx_if.tvalid = ($urandom_range(0, 99) >= gap_pct);
      rx_if.tdata  = pattern(m_mode, src);
      if (src == bad_a) rx_if.tdata = 64'hDEAD;
      if (src == bad_b) rx_if.tdata = rx_if.tdata ^ 64'h1;
      if (!rx_if.tvalid) rx_if.tdata = {$urandom, $urandom};
      if (src >= drop_at) begin link = 1'b0; rx_if.tvalid = 1'b0; end
      if (drop_on_last && src == int'(SeqLen) - 1 && m_phase == PhRun) link = 1'b0;
      tick();
      if (m_acc) src++;
      cyc++;
    end
    start = 1'b0; rx_if.tvalid = 1'b0; link = 1'b1;
    chk("run_reached_done", 64'(m_phase == PhDone), 64'd1);
  endtask

  initial begin
    int run_cycles;
    prbs_tab[0] = Seed;
    for (int i = 1; i < 64; i++) begin
      prbs_tab[i] = {prbs_tab[i-1][62:0],
                     prbs_tab[i-1][63] ^ prbs_tab[i-1][62] ^ prbs_tab[i-1][60] ^ prbs_tab[i-1][59]};
    end
    chk("model_prbs_step1", prbs_tab[1], 64'h0246_8ACF_1357_9BDE);

    m_phase = PhIdle; m_mode = 1'b0; m_runcyc = 0; model_clear();
    arst = 1'b1; start = 1'b0; mode = 1'b0; link = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tdata = '0;
    tick(); tick();
    arst = 1'b0;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_tready", 64'(rx_if.tready), 64'd0);

    // Clean counter run, then two drained beats.
    do_start(1'b0);
    chk("start_busy", 64'(busy), 64'd1);
    run_traffic(0, -1, -1, 1000, 1'b0, 1'b0);
    chk("cnt_rx", 64'(rx_cnt), 64'd16);
    chk("cnt_pass", 64'(pass), 64'd1);
    chk("cnt_flags", 64'(flags), 64'd0);
    rx_if.tvalid = 1'b1; tick(); tick(); rx_if.tvalid = 1'b0; tick();
    chk("ovf_flags", 64'(flags), 64'b100);
    chk("ovf_pass", 64'(pass), 64'd0);
    chk("ovf_rx", 64'(rx_cnt), 64'd16);

    // PRBS with random gaps.
    do_start(1'b1);
    run_traffic(30, -1, -1, 1000, 1'b0, 1'b0);
    chk("prbs_pass", 64'(pass), 64'd1);
    chk("prbs_rx", 64'(rx_cnt), 64'd16);

    // Corrupted beats 5 and 9.
    do_start(1'b0);
    run_traffic(0, 5, 9, 1000, 1'b0, 1'b0);
    chk("err_cnt2", 64'(err_cnt), 64'd2);
    chk("err_idx", 64'(first_err_idx), 64'd5);
    chk("err_data", first_err_data, 64'hDEAD);
    chk("err_pass", 64'(pass), 64'd0);

    // Link lost after 7 beats.
    do_start(1'b0);
    run_traffic(0, -1, -1, 7, 1'b0, 1'b0);
    chk("lost_done", 64'(done), 64'd1);
    chk("lost_flags", 64'(flags), 64'b001);
    chk("lost_rx", 64'(rx_cnt), 64'd7);
    chk("lost_pass", 64'(pass), 64'd0);

    // Link falls on the last beat: beat counted, LINK_LOST still set.
    do_start(1'b1);
    run_traffic(0, -1, -1, 1000, 1'b1, 1'b0);
    chk("lastlost_rx", 64'(rx_cnt), 64'd16);
    chk("lastlost_flags", 64'(flags), 64'b001);

    // No traffic: timeout after exactly Tmo RUN cycles.
    do_start(1'b0);
    run_cycles = 0;
    for (int i = 0; i < 300 && m_phase != PhDone; i++) begin
      tick();
      if (busy && rx_if.tready) run_cycles++;
    end
    chk("tmo_run_cycles", 64'(run_cycles), 64'd100);
    chk("tmo_flags", 64'(flags), 64'b010);

    // Reset mid-run, then a fresh clean run.
    do_start(1'b0);
    rx_if.tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin rx_if.tdata = 64'(i); tick(); end
    arst = 1'b1; rx_if.tvalid = 1'b0; tick(); arst = 1'b0;
    chk("arst_rx", 64'(rx_cnt), 64'd0);
    chk("arst_flags", 64'(flags), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    tick();
    do_start(1'b0);
    run_traffic(0, -1, -1, 1000, 1'b0, 1'b0);
    chk("arst_rerun_pass", 64'(pass), 64'd1);

    // Randomized runs with errors, drops, gaps and ignored START pulses.
    for (int r = 0; r < 8; r++) begin
      do_start(1'($urandom));
      run_traffic(int'($urandom_range(0, 40)), int'($urandom_range(0, 24)),
                  int'($urandom_range(0, 24)), int'($urandom_range(3, 40)), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        rx_if.tvalid = 1'($urandom); tick();
      end
      rx_if.tvalid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
